// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, with a one-deep response register.
// Tie policy: fixed priority to requester 0 by default, round-robin when ALU_ARB_ROUND_ROBIN_EN is defined.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_oper,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_oper,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic [3:0]       alu_oper,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [31:0]      rsp_result,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    logic can_issue;
    logic tie_pick;
    logic gnt0;
    logic gnt1;
    logic last_winner;

    always_comb begin
        can_issue = !rsp_valid || rsp_ready;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        tie_pick = ~last_winner;
`else
        // Fixed priority: last_winner is still tracked but never steers the tie.
        tie_pick = last_winner & 1'b0;
`endif
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && can_issue) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !tie_pick;
                gnt1 = tie_pick;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        alu_oper = 4'd0;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        if (gnt0) begin
            alu_oper = req0_oper;
            alu_a    = req0_a;
            alu_b    = req0_b;
        end else if (gnt1) begin
            alu_oper = req1_oper;
            alu_a    = req1_a;
            alu_b    = req1_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= 32'd0;
            gnt_cnt0    <= '0;
            gnt_cnt1    <= '0;
            last_winner <= 1'b1;
        end else begin
            if (gnt0 || gnt1) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= gnt1;
                rsp_result  <= alu_result;
                last_winner <= gnt1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Counters saturate rather than wrap.
            if (gnt0 && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt1 && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued at grant time and popped by a
// monitor on each response handshake; a second instance with CNT_W=2 exercises counter saturation.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_oper, req1_oper;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_oper;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_result;
    logic [15:0] gnt_cnt0, gnt_cnt1;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [3:0]  s_alu_oper;
    logic [31:0] s_alu_a, s_alu_b, s_rsp_result;
    logic [1:0]  s_gnt_cnt0, s_gnt_cnt1;

    typedef struct {
        logic        id;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External ALU model: 0 add, 1 sub, 2 and, 3 or, otherwise xor.
    always_comb begin
        case (alu_oper)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_oper(req0_oper),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_oper(req1_oper),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    alu_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_oper(req0_oper),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_oper(req1_oper),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_oper(s_alu_oper), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(alu_result),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_result(s_rsp_result), .rsp_ready(rsp_ready),
        .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
        req0_valid = v0; req0_oper = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_oper = o1; req1_a = a1; req1_b = b1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic push(input logic id, input logic [31:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    // Step to 1 time unit after the next rising edge; inputs are driven there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake consumes one queued expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id %0d result %0d with no response expected", rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_result !== e.res) begin
                    errors++;
                    $display("FAIL sb_rsp: got id %0d result %0d expected id %0d result %0d",
                             rsp_id, rsp_result, e.id, e.res);
                end
            end
        end
    end

    logic exp_w[4];
    logic w;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        idle();

        // Reset: readies and ALU drives forced low even with a valid request.
        step();
        drive(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cnt0", gnt_cnt0, 0);

        // Single requester ADD 5+7.
        step();
        rst = 1'b0;
        #2;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        chk("add_alu_a", alu_a, 5);
        push(1'b0, 32'd12);
        step();
        idle();
        #2;
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_id", rsp_id, 0);
        chk("add_rsp_result", rsp_result, 12);
        chk("add_cnt0", gnt_cnt0, 1);
        chk("idle_ready0", req0_ready, 0);
        chk("idle_alu_oper", alu_oper, 0);

        // Continuous contention for 4 cycles.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 4'd0, 32'd10, 32'd20);
            #2;
            w = exp_w[i];
            chk("tie_ready0", req0_ready, !w);
            chk("tie_ready1", req1_ready, w);
            push(w, w ? 32'd30 : 32'd3);
            step();
        end
        idle();
        #2;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        chk("tie_cnt0", gnt_cnt0, 2);
        chk("tie_cnt1", gnt_cnt1, 2);
        chk("tie_s_cnt0", s_gnt_cnt0, 2);
`else
        chk("tie_cnt0", gnt_cnt0, 4);
        chk("tie_cnt1", gnt_cnt1, 0);
        chk("tie_s_cnt0_sat", s_gnt_cnt0, 3);
`endif

        // Back-pressure: SUB 9-4 held while rsp_ready is low, req1 waiting.
        step();
        drive(1'b1, 4'd1, 32'd9, 32'd4, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        chk("sub_ready0", req0_ready, 1);
        push(1'b0, 32'd5);
        step();
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'd3, 32'd3);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_result", rsp_result, 5);
            chk("hold_ready0", req0_ready, 0);
            chk("hold_ready1", req1_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        #2;
        chk("release_ready1", req1_ready, 1);
        push(1'b1, 32'd6);
        step();
        idle();
        #2;
        chk("release_rsp_valid", rsp_valid, 1);
        chk("release_rsp_id", rsp_id, 1);
        chk("release_rsp_result", rsp_result, 6);
        step();
        #2;
        chk("drain_valid", rsp_valid, 0);

        // Saturation of the 2-bit counter over five req1 grants.
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'hF0, 32'h3C);
        push(1'b1, 32'h30);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) push(1'b1, 32'h30);
            else idle();
            #2;
            chk("sat_s_cnt1", s_gnt_cnt1, (i < 2) ? i + 1 : 3);
            chk("sat_cnt1", gnt_cnt1, i + 1);
        end

        // Reset while a response is held discards it and restores requester-0 tie priority.
        step();
        drive(1'b1, 4'd0, 32'd2, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
        #2;
        push(1'b0, 32'd4);
        step();
        idle();
        rsp_ready = 1'b0;
        #2;
        chk("pre_rst_valid", rsp_valid, 1);
        step();
        rst = 1'b1;
        drive(1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 4'd0, 32'd10, 32'd20);
        #2;
        chk("rst_hold_ready0", req0_ready, 0);
        chk("rst_hold_ready1", req1_ready, 0);
        step();
        #2;
        chk("rst_drop_valid", rsp_valid, 0);
        chk("rst_drop_cnt0", gnt_cnt0, 0);
        chk("rst_drop_cnt1", gnt_cnt1, 0);
        chk("rst_drop_sb", sb.size(), 1);
        sb.delete();
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rst_tie0", req0_ready, 1);
        chk("post_rst_tie1", req1_ready, 0);
        push(1'b0, 32'd3);
        step();
        idle();
        #2;
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_result", rsp_result, 3);

        step();
        step();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
